// File: rtl/branch_sequencer_if.sv
// Decode-side bundle for branch_sequencer: instruction class and ALU flags in,
// PC/write-data mux selects, link write, jm memory handshake and status out.
// Optional: BRANCH_SEQ_TAKEN_CNT_EN adds the 16-bit taken_cnt signal.
interface branch_sequencer_if;
    logic       instr_valid;
    logic [2:0] bnj;
    logic       flag_we;
    logic       alu_zero;
    logic       alu_neg;
    logic       mem_ready;
    logic [1:0] pc_sel;
    logic       jbrn_sel;
    logic       wrtdat_sel;
    logic       link_we;
    logic       mem_rd_req;
    logic       stall;
    logic       flush;
    logic       stat_z;
    logic       stat_n;
    logic       illegal_op;
`ifdef BRANCH_SEQ_TAKEN_CNT_EN
    logic [15:0] taken_cnt;
`endif

    // Decode / datapath side
    modport master (
        output instr_valid, bnj, flag_we, alu_zero, alu_neg, mem_ready,
        input  pc_sel, jbrn_sel, wrtdat_sel, link_we, mem_rd_req, stall,
               flush, stat_z, stat_n, illegal_op
`ifdef BRANCH_SEQ_TAKEN_CNT_EN
        , input taken_cnt
`endif
    );

    // Sequencer side
    modport slave (
        input  instr_valid, bnj, flag_we, alu_zero, alu_neg, mem_ready,
        output pc_sel, jbrn_sel, wrtdat_sel, link_we, mem_rd_req, stall,
               flush, stat_z, stat_n, illegal_op
`ifdef BRANCH_SEQ_TAKEN_CNT_EN
        , output taken_cnt
`endif
    );
endinterface

// File: rtl/branch_sequencer.sv
// Jump/branch PC-source sequencer. Holds the Z/N status register, resolves
// j/beq/bgez/brn/balz in the decode cycle, and runs the jm memory-read
// handshake (with timeout) before redirecting to the fetched word.
// Optional: BRANCH_SEQ_TAKEN_CNT_EN enables a saturating count of redirects.
module branch_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input logic            clk,
    input logic            reset,
    branch_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        RUN     = 2'b00,
        JM_RD   = 2'b01,
        JM_TAKE = 2'b10,
        FLUSH   = 2'b11
    } state_t;

    localparam logic [3:0] TIMEOUT = 4'(MEM_TIMEOUT);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wait_cnt;
    logic       stat_z;
    logic       stat_n;

    logic [1:0] pc_sel;
    logic       jbrn_sel;
    logic       wrtdat_sel;
    logic       link_we;
    logic       mem_rd_req;
    logic       stall;
    logic       flush;
    logic       illegal_op;

    // Output decode and next state. RUN decisions must land in the same cycle
    // as instr_valid, so outputs are decoded from the registered state plus the
    // current inputs rather than registered themselves; reset forces RUN and so
    // drops mem_rd_req/stall asynchronously.
    always_comb begin
        state_nxt  = state;
        pc_sel     = 2'b00;
        jbrn_sel   = 1'b0;
        wrtdat_sel = 1'b0;
        link_we    = 1'b0;
        mem_rd_req = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        illegal_op = 1'b0;
        case (state)
            RUN: begin
                if (bus.instr_valid) begin
                    case (bus.bnj)
                        3'b001: pc_sel = 2'b01;
                        3'b010: if (stat_z)  pc_sel = 2'b11;
                        3'b011: if (!stat_n) pc_sel = 2'b11;
                        3'b100: begin
                            jbrn_sel = 1'b1;
                            if (stat_n) pc_sel = 2'b01;
                        end
                        3'b101: state_nxt = JM_RD;
                        3'b110: begin
                            if (stat_z) begin
                                pc_sel     = 2'b01;
                                wrtdat_sel = 1'b1;
                                link_we    = 1'b1;
                            end
                        end
                        3'b111: illegal_op = 1'b1;
                        default: ;
                    endcase
                    if (pc_sel != 2'b00) state_nxt = FLUSH;
                end
            end
            JM_RD: begin
                mem_rd_req = 1'b1;
                stall      = 1'b1;
                // mem_ready in the timeout cycle still wins over the abort
                if (bus.mem_ready) begin
                    state_nxt = JM_TAKE;
                end else if (wait_cnt == TIMEOUT) begin
                    illegal_op = 1'b1;
                    state_nxt  = RUN;
                end
            end
            JM_TAKE: begin
                pc_sel    = 2'b10;
                state_nxt = FLUSH;
            end
            FLUSH: begin
                flush     = 1'b1;
                state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // State register, jm wait counter and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            stat_z   <= 1'b0;
            stat_n   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == JM_RD && state_nxt == JM_RD) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= '0;
            end
            if (bus.flag_we) begin
                stat_z <= bus.alu_zero;
                stat_n <= bus.alu_neg;
            end
        end
    end

`ifdef BRANCH_SEQ_TAKEN_CNT_EN
    logic [15:0] taken_cnt;

    // Saturating count of entries into FLUSH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taken_cnt <= '0;
        end else if (state_nxt == FLUSH && taken_cnt != '1) begin
            taken_cnt <= taken_cnt + 16'd1;
        end
    end

    assign bus.taken_cnt = taken_cnt;
`endif

    assign bus.pc_sel     = pc_sel;
    assign bus.jbrn_sel   = jbrn_sel;
    assign bus.wrtdat_sel = wrtdat_sel;
    assign bus.link_we    = link_we;
    assign bus.mem_rd_req = mem_rd_req;
    assign bus.stall      = stall;
    assign bus.flush      = flush;
    assign bus.stat_z     = stat_z;
    assign bus.stat_n     = stat_n;
    assign bus.illegal_op = illegal_op;
endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: a per-cycle vector table for the
// RUN-state decode and status register, then hand sequences for jm, jm
// timeout, asynchronous reset mid-jm and (when enabled) taken_cnt.
module tb_branch_sequencer;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    branch_sequencer_if bus();

    branch_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [2:0]  bnj;
        logic        fwe;
        logic        az;
        logic        an;
        logic        mr;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl [21];

    // Expected-output word: {pc_sel, jbrn, wrtdat, link, mem_rd_req, stall, flush, z, n, illegal}
    function automatic logic [10:0] mk(input logic [1:0] pc, input logic jb, input logic wd,
                                       input logic lk, input logic mq, input logic st,
                                       input logic fl, input logic z, input logic n,
                                       input logic il);
        return {pc, jb, wd, lk, mq, st, fl, z, n, il};
    endfunction

    function automatic vec_t v(input logic iv, input logic [2:0] bnj, input logic fwe,
                               input logic az, input logic an, input logic mr,
                               input logic [10:0] exp);
        vec_t r;
        r.iv = iv; r.bnj = bnj; r.fwe = fwe; r.az = az; r.an = an; r.mr = mr; r.exp = exp;
        return r;
    endfunction

    function automatic logic [10:0] outs();
        return {bus.pc_sel, bus.jbrn_sel, bus.wrtdat_sel, bus.link_we, bus.mem_rd_req,
                bus.stall, bus.flush, bus.stat_z, bus.stat_n, bus.illegal_op};
    endfunction

    task automatic chk(input string name, input logic [10:0] got, input logic [10:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b required %b (pc,jb,wd,lk,mq,st,fl,z,n,il)", name, got, exp);
        end
    endtask

    // One clock cycle: drive just after the rising edge, check on the falling edge
    task automatic cyc(input string name, input logic iv, input logic [2:0] bnj,
                       input logic fwe, input logic az, input logic an, input logic mr,
                       input logic [10:0] exp);
        @(posedge clk);
        #1;
        bus.instr_valid = iv;
        bus.bnj         = bnj;
        bus.flag_we     = fwe;
        bus.alu_zero    = az;
        bus.alu_neg     = an;
        bus.mem_ready   = mr;
        @(negedge clk);
        chk(name, outs(), exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.instr_valid = 1'b0;
        bus.bnj         = 3'b000;
        bus.flag_we     = 1'b0;
        bus.alu_zero    = 1'b0;
        bus.alu_neg     = 1'b0;
        bus.mem_ready   = 1'b0;

        tbl[0]  = v(0, 3'd0, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl[1]  = v(0, 3'd0, 1, 1, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl[2]  = v(1, 3'd2, 0, 0, 0, 0, mk(2'd3, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl[3]  = v(1, 3'd1, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl[4]  = v(1, 3'd2, 1, 0, 0, 0, mk(2'd3, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl[5]  = v(0, 3'd0, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl[6]  = v(1, 3'd2, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl[7]  = v(1, 3'd3, 0, 0, 0, 0, mk(2'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl[8]  = v(0, 3'd0, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl[9]  = v(0, 3'd0, 1, 0, 1, 0, mk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl[10] = v(1, 3'd3, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl[11] = v(1, 3'd4, 0, 0, 0, 0, mk(2'd1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl[12] = v(0, 3'd0, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        tbl[13] = v(1, 3'd1, 1, 1, 0, 0, mk(2'd1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl[14] = v(0, 3'd0, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl[15] = v(1, 3'd6, 0, 0, 0, 0, mk(2'd1, 0, 1, 1, 0, 0, 0, 1, 0, 0));
        tbl[16] = v(0, 3'd0, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl[17] = v(1, 3'd4, 1, 0, 0, 0, mk(2'd0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl[18] = v(1, 3'd6, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl[19] = v(1, 3'd7, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl[20] = v(0, 3'd0, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", outs(), mk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef BRANCH_SEQ_TAKEN_CNT_EN
        tests++;
        if (bus.taken_cnt !== 16'd0) begin
            fails++;
            $display("FAIL reset_taken_cnt: got %0d required 0", bus.taken_cnt);
        end
`endif
        reset = 1'b0;

        // RUN-state decode and status register
        for (int i = 0; i < 21; i++) begin
            cyc($sformatf("vec%0d", i), tbl[i].iv, tbl[i].bnj, tbl[i].fwe,
                tbl[i].az, tbl[i].an, tbl[i].mr, tbl[i].exp);
        end

        // jm, mem_ready at k=3; branch and instr_valid ignored during JM_RD,
        // flag_we still honoured
        cyc("jm3_issue", 1, 3'd5, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("jm3_c0",    1, 3'd1, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        cyc("jm3_c1",    0, 3'd0, 1, 1, 0, 0, mk(2'd0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        cyc("jm3_c2",    0, 3'd0, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 1, 1, 0, 1, 0, 0));
        cyc("jm3_c3",    0, 3'd0, 0, 0, 0, 1, mk(2'd0, 0, 0, 0, 1, 1, 0, 1, 0, 0));
        cyc("jm3_c4",    0, 3'd0, 0, 0, 0, 0, mk(2'd2, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        cyc("jm3_c5",    0, 3'd0, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        cyc("jm3_c6",    0, 3'd0, 1, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        cyc("jm3_c7",    0, 3'd0, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // jm, mem_ready in the first JM_RD cycle (k=0)
        cyc("jm0_issue", 1, 3'd5, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("jm0_c0",    0, 3'd0, 0, 0, 0, 1, mk(2'd0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        cyc("jm0_c1",    0, 3'd0, 0, 0, 0, 0, mk(2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("jm0_c2",    0, 3'd0, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        cyc("jm0_c3",    0, 3'd0, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // jm timeout: abort pulse in JM_RD cycle 15, then RUN with no redirect
        cyc("jmto_issue", 1, 3'd5, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int c = 0; c < 16; c++) begin
            cyc($sformatf("jmto_c%0d", c), 0, 3'd0, 0, 0, 0, 0,
                mk(2'd0, 0, 0, 0, 1, 1, 0, 0, 0, (c == 15) ? 1'b1 : 1'b0));
        end
        cyc("jmto_after", 0, 3'd0, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("jmto_j",     1, 3'd1, 0, 0, 0, 0, mk(2'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("jmto_flush", 0, 3'd0, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0));

        // Asynchronous reset in the middle of JM_RD
        cyc("jmrst_flag",  0, 3'd0, 1, 1, 1, 0, mk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("jmrst_issue", 1, 3'd5, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        cyc("jmrst_c0",    0, 3'd0, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 1, 1, 0, 1, 1, 0));
        cyc("jmrst_c1",    0, 3'd0, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 1, 1, 0, 1, 1, 0));
        #1;
        reset = 1'b1;
        #1;
        chk("jmrst_async", outs(), mk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b0;
        cyc("jmrst_after", 0, 3'd0, 0, 0, 0, 1, mk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("jmrst_idle",  0, 3'd0, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

`ifdef BRANCH_SEQ_TAKEN_CNT_EN
        // Three taken redirects from a fresh reset
        do_reset();
        for (int t = 0; t < 3; t++) begin
            cyc($sformatf("cnt_j%0d", t), 1, 3'd1, 0, 0, 0, 0, mk(2'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            cyc($sformatf("cnt_f%0d", t), 0, 3'd0, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        end
        cyc("cnt_nt", 1, 3'd2, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tests++;
        if (bus.taken_cnt !== 16'd3) begin
            fails++;
            $display("FAIL taken_cnt: got %0d required 3", bus.taken_cnt);
        end
`else
        do_reset();
        cyc("final_idle", 0, 3'd0, 0, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Multi-cycle controller that sequences PC-source selection for the jump/branch datapath. It holds the Z/N status register and resolves beq/bgez/brn/balz/j/jm into PC mux selects, link-write enables and pipeline flushes. For jm it runs a memory-read handshake to fetch the target word and stalls fetch until the word arrives. It sits between instruction decode and the PC mux / register-file write-data mux.

## Interface

- `MEM_TIMEOUT`, default 15: maximum cycles to wait for `mem_ready` before aborting a jm; 4-bit range.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `instr_valid`  in  1  decode presents a new instruction this cycle.
- `bnj`  in  3  class: 000 R/lw/sw/andi, 001 j, 010 beq, 011 bgez, 100 brn, 101 jm, 110 balz, 111 illegal.
- `flag_we`  in  1  latch `alu_zero` and `alu_neg` into the status register.
- `alu_zero`, `alu_neg`  in  1 each  ALU flags.
- `mem_ready`  in  1  jm target word valid on the data bus.
- `pc_sel`  out  2  00 PC+4, 01 jump target, 10 memory word, 11 branch target.
- `jbrn_sel`  out  1  jump target comes from register (brn).
- `wrtdat_sel`  out  1  write-data mux selects link address.
- `link_we`  out  1  register-file write of link address.
- `mem_rd_req`  out  1  jm target read request.
- `stall`  out  1  hold PC and decode.
- `flush`  out  1  squash the instruction fetched after a redirect.
- `stat_z`, `stat_n`  out  1 each  status register.
- `illegal_op`  out  1  one-cycle pulse on bnj=111 or jm timeout.

## Operation

- Status register: on `flag_we`, `stat_z<=alu_zero`, `stat_n<=alu_neg`. Branch decisions always use the registered value. A same-cycle `flag_we` affects the next instruction only.
- FSM states are RUN, JM_RD, JM_TAKE and FLUSH. Reset state is RUN.
- RUN with `instr_valid` decodes `bnj` combinationally. Taken means `pc_sel`≠00.
  - 000: pc_sel 00.
  - 001 j: pc_sel 01.
  - 010 beq: pc_sel 11 if stat_z.
  - 011 bgez: pc_sel 11 if !stat_n.
  - 100 brn: jbrn_sel 1; pc_sel 01 if stat_n.
  - 110 balz: pc_sel 01 and wrtdat_sel 1 and link_we 1 if stat_z, otherwise all 0.
  - 101 jm: go to JM_RD.
  - 111: illegal_op pulses and the instruction is treated as 000.
  - If taken, go to FLUSH.
- JM_RD: `mem_rd_req=1` and `stall=1`.
  - An internal 4-bit counter starts at 0.
  - On `mem_ready`, go to JM_TAKE.
  - If the counter reaches MEM_TIMEOUT without `mem_ready`, pulse illegal_op and return to RUN with pc_sel 00.
- JM_TAKE: `pc_sel=10`, stall 0, then go to FLUSH.
- FLUSH: `flush=1` for one cycle, outputs otherwise default, then go to RUN. `instr_valid` is ignored.
- In JM_RD, `instr_valid` and `bnj` are ignored.
- `flag_we` is honoured in every state.

## Timing

- Reset values: every output is 0, stat_z=stat_n=0, state RUN, counter 0.
- Reset mid-jm drops `mem_rd_req` asynchronously, with no redirect.
- RUN decisions have zero latency: same cycle as `instr_valid`.
- `flush` asserts the cycle after a taken redirect.
- jm latency: request cycle 0, `mem_ready` seen at cycle k, pc_sel=10 at k+1, flush at k+2.
- `mem_ready` is sampled only in JM_RD. If it is present in the first JM_RD cycle, k=0.
- Back-to-back taken branches are impossible: the FLUSH cycle separates them.

## Configuration

- `BRANCH_SEQ_TAKEN_CNT_EN` defined:
  - Adds output `taken_cnt`, 16 bits, counting cycles entering FLUSH.
  - The counter saturates at 16'hFFFF and clears on reset.
- Undefined: the port and counter are absent, with no other behavioural change.

## Test plan

- Reset, then `flag_we` with zero=1 and neg=0, then beq valid next cycle → stat_z=1, pc_sel=11, flush=1 one cycle later, then pc_sel=00.
- flag_we (zero=0) in the same cycle as beq, with prior stat_z=1 → beq taken using the old flag; stat_z=0 afterward.
- balz with stat_z=1 → pc_sel=01, wrtdat_sel=1, link_we=1. balz with stat_z=0 → all 0 and no flush.
- jm with `mem_ready` after 3 cycles → mem_rd_req and stall high for 4 cycles, pc_sel=10 at cycle 4, flush at cycle 5.
- jm with `mem_ready` never asserted, MEM_TIMEOUT=15 → illegal_op pulse at cycle 15, return to RUN; reset asserted mid-JM_RD drops mem_rd_req immediately.
- bnj=111 → illegal_op one-cycle pulse, pc_sel=00. With the macro defined, 3 taken branches → taken_cnt=3.
